conway_pixel_fetch: RTL

CONWAY_PIXEL_FETCH -- requirements
Module: conway_pixel_fetch

---
 rtl/conway_pixel_fetch.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/conway_pixel_fetch.sv
// Streams a Life grid buffer from word memory as a raster of single-bit pixels.
// Reads are credit-limited against a 4-entry word FIFO feeding a 20-bit serializer.
module conway_pixel_fetch #(
    parameter int unsigned WORDS_PER_ROW = 64,
    parameter int unsigned ROWS          = 1024,
    parameter int unsigned READ_LATENCY  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        buf_sel,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_sel,
    input  logic        mem_wait,
    input  logic [19:0] mem_q,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_data,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        frame_done
);

    localparam int unsigned LastCol = WORDS_PER_ROW * 20 - 1;

    typedef enum logic [1:0] {StIdle, StStream, StFinish} state_e;

    state_e      state_q;
    logic        mem_rd_q;
    logic [15:0] mem_addr_q;
    logic        mem_sel_q;
    logic        frame_done_q;
    logic [15:0] rd_word_q;
    logic [9:0]  rd_row_q;
    logic        all_issued_q;

    logic [READ_LATENCY-1:0] tag_q;
    logic [READ_LATENCY-1:0] tag_d;

    logic [19:0] fifo_mem_q [4];
    logic [1:0]  wr_ptr_q;
    logic [1:0]  rd_ptr_q;
    logic [2:0]  fifo_cnt_q;
    logic [2:0]  fifo_cnt_d;
    logic [19:0] fifo_out;

    logic [19:0] sh_q;
    logic [4:0]  sh_cnt_q;
    logic [10:0] col_q;
    logic [9:0]  row_q;

    logic        rd_accept;
    logic        push;
    logic        pop;
    logic        pix_accept;
    logic        last_pix;
    logic        credit_ok;
    logic [15:0] next_addr;
    int unsigned inflight_d;

    always_comb begin
        rd_accept = mem_rd_q & ~mem_wait;
        tag_d     = '0;
        tag_d[0]  = rd_accept;
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            tag_d[i] = tag_q[i-1];
        end
        inflight_d = 0;
        for (int i = 0; i < int'(READ_LATENCY); i++) begin
            inflight_d = inflight_d + 32'(tag_d[i]);
        end
    end

    always_comb begin
        push       = tag_q[READ_LATENCY-1];
        // An empty FIFO forwards the arriving word straight to the serializer.
        fifo_out   = (fifo_cnt_q == 3'd0) ? mem_q : fifo_mem_q[rd_ptr_q];
        pix_accept = (sh_cnt_q != 5'd0) & pix_ready;
        pop        = ((fifo_cnt_q != 3'd0) || push) &&
                     ((sh_cnt_q == 5'd0) || ((sh_cnt_q == 5'd1) && pix_accept));
        fifo_cnt_d = fifo_cnt_q + {2'b00, push} - {2'b00, pop};
        credit_ok  = (32'(fifo_cnt_d) + inflight_d) < 32'd4;
        last_pix   = pix_accept && (col_q == 11'(LastCol)) && (row_q == 10'(ROWS - 1));
        next_addr  = 16'(32'(rd_row_q) * WORDS_PER_ROW + 32'(rd_word_q));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            mem_rd_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_sel_q    <= 1'b0;
            frame_done_q <= 1'b0;
            rd_word_q    <= '0;
            rd_row_q     <= '0;
            all_issued_q <= 1'b0;
        end else begin
            frame_done_q <= last_pix;
            case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_q      <= StStream;
                        mem_sel_q    <= buf_sel;
                        rd_word_q    <= '0;
                        rd_row_q     <= '0;
                        all_issued_q <= 1'b0;
                    end
                end
                StStream: begin
                    // A stalled request keeps address and strobe until accepted.
                    if (!mem_rd_q || rd_accept) begin
                        if (!all_issued_q && credit_ok) begin
                            mem_rd_q   <= 1'b1;
                            mem_addr_q <= next_addr;
                            if (rd_word_q == 16'(WORDS_PER_ROW - 1)) begin
                                rd_word_q <= '0;
                                if (rd_row_q == 10'(ROWS - 1)) begin
                                    all_issued_q <= 1'b1;
                                end else begin
                                    rd_row_q <= rd_row_q + 10'd1;
                                end
                            end else begin
                                rd_word_q <= rd_word_q + 16'd1;
                            end
                        end else begin
                            mem_rd_q <= 1'b0;
                        end
                    end
                    if (rd_accept && all_issued_q) begin
                        state_q <= StFinish;
                    end
                end
                StFinish: begin
                    if (last_pix) begin
                        if (enable) begin
                            state_q      <= StStream;
                            mem_sel_q    <= buf_sel;
                            rd_word_q    <= '0;
                            rd_row_q     <= '0;
                            all_issued_q <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            sh_q       <= '0;
            sh_cnt_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
        end else begin
            tag_q      <= tag_d;
            fifo_cnt_q <= fifo_cnt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
                sh_q     <= fifo_out;
                sh_cnt_q <= 5'd20;
            end else if (pix_accept) begin
                sh_q     <= {sh_q[18:0], 1'b0};
                sh_cnt_q <= sh_cnt_q - 5'd1;
            end
            if (pix_accept) begin
                if (col_q == 11'(LastCol)) begin
                    col_q <= '0;
                    row_q <= (row_q == 10'(ROWS - 1)) ? 10'd0 : row_q + 10'd1;
                end else begin
                    col_q <= col_q + 11'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= mem_q;
        end
    end

    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;
    assign mem_sel    = mem_sel_q;
    assign frame_done = frame_done_q;
    assign pix_valid  = (sh_cnt_q != 5'd0);
    assign pix_data   = sh_q[19];
    assign pix_sof    = pix_valid && (col_q == 11'd0) && (row_q == 10'd0);
    assign pix_eol    = pix_valid && (col_q == 11'(LastCol));

endmodule
